// File: rtl/axi_lite_reg_slave_pkg.sv
// rtl/axi_lite_reg_slave_pkg.sv - response codes and FSM state types for the AXI-Lite register slave
package axi_lite_reg_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI-Lite word register file with independent read/write FSMs
// Optional macro AXI_LITE_REG_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave
    import axi_lite_reg_slave_pkg::*;
#(
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int NUM_REGS       = 8
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [AXI_WIDTH_ADDR-1:0]          s_axi_lite_awaddr,
    input  logic                               s_axi_lite_awvalid,
    output logic                               s_axi_lite_awready,
    input  logic [AXI_WIDTH_DATA-1:0]          s_axi_lite_wdata,
    input  logic                               s_axi_lite_wvalid,
    output logic                               s_axi_lite_wready,
    output logic [1:0]                         s_axi_lite_bresp,
    output logic                               s_axi_lite_bvalid,
    input  logic                               s_axi_lite_bready,
    input  logic [AXI_WIDTH_ADDR-1:0]          s_axi_lite_araddr,
    input  logic                               s_axi_lite_arvalid,
    output logic                               s_axi_lite_arready,
    output logic [AXI_WIDTH_DATA-1:0]          s_axi_lite_rdata,
    output logic [1:0]                         s_axi_lite_rresp,
    output logic                               s_axi_lite_rvalid,
    input  logic                               s_axi_lite_rready,
    output logic [NUM_REGS*AXI_WIDTH_DATA-1:0] regs_o,
    output logic [NUM_REGS-1:0]                wr_pulse_o
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int WA_W  = AXI_WIDTH_ADDR - 2;

`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    // Word address only: the byte-lane bits never take part in decode.
    function automatic logic in_range(input logic [WA_W-1:0] wa);
        return wa[WA_W-1:IDX_W] == '0;
    endfunction

    logic [AXI_WIDTH_DATA-1:0] regs [NUM_REGS];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [WA_W-1:0]           aw_addr_q;
    logic [AXI_WIDTH_DATA-1:0] w_data_q;
    logic [WA_W-1:0]           ar_word;
    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                      unused_byte_bits;

    assign unused_byte_bits = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};
    assign ar_word          = s_axi_lite_araddr[AXI_WIDTH_ADDR-1:2];

    assign aw_hs = s_axi_lite_awvalid & s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid  & s_axi_lite_wready;
    assign b_hs  = s_axi_lite_bvalid  & s_axi_lite_bready;
    assign ar_hs = s_axi_lite_arvalid & s_axi_lite_arready;
    assign r_hs  = s_axi_lite_rvalid  & s_axi_lite_rready;

    assign s_axi_lite_bvalid = (w_state == W_RESP);
    assign s_axi_lite_rvalid = (r_state == R_RESP);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_o[gi*AXI_WIDTH_DATA +: AXI_WIDTH_DATA] = regs[gi];
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)  w_next = W_COMMIT;
            W_HAVE_D: if (aw_hs) w_next = W_COMMIT;
            W_COMMIT:            w_next = W_RESP;
            W_RESP:   if (b_hs)  w_next = W_IDLE;
            default:             w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (r_hs)  r_next = R_IDLE;
            default:            r_next = R_IDLE;
        endcase
    end

    // Readies come from the next state so they stay low during reset and rise one edge after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state            <= W_IDLE;
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            aw_addr_q          <= '0;
            w_data_q           <= '0;
        end else begin
            w_state            <= w_next;
            s_axi_lite_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
            s_axi_lite_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
            if (aw_hs) aw_addr_q <= s_axi_lite_awaddr[AXI_WIDTH_ADDR-1:2];
            if (w_hs)  w_data_q  <= s_axi_lite_wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse_o       <= '0;
            s_axi_lite_bresp <= RESP_OKAY;
        end else begin
            wr_pulse_o <= '0;
            if (w_state == W_COMMIT) begin
                if (in_range(aw_addr_q)) begin
                    regs[aw_addr_q[IDX_W-1:0]]       <= w_data_q;
                    wr_pulse_o[aw_addr_q[IDX_W-1:0]] <= 1'b1;
                    s_axi_lite_bresp                 <= RESP_OKAY;
                end else begin
                    s_axi_lite_bresp <= OOR_RESP;
                end
            end
        end
    end

    // rdata samples the array before any same-edge commit lands, so a colliding read sees the old value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state            <= R_IDLE;
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rdata   <= '0;
            s_axi_lite_rresp   <= RESP_OKAY;
        end else begin
            r_state            <= r_next;
            s_axi_lite_arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                if (in_range(ar_word)) begin
                    s_axi_lite_rdata <= regs[ar_word[IDX_W-1:0]];
                    s_axi_lite_rresp <= RESP_OKAY;
                end else begin
                    s_axi_lite_rdata <= '0;
                    s_axi_lite_rresp <= OOR_RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - directed plus randomized self-checking bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [AW-1:0]  awaddr, araddr;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [DW-1:0]  wdata, rdata;
    logic [1:0]     bresp, rresp;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]  wr_pulse_o;

    axi_lite_reg_slave #(.AXI_WIDTH_ADDR(AW), .AXI_WIDTH_DATA(DW), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int pulse_count = 0;
    logic [DW-1:0] model [NR];

    always @(negedge aclk) pulse_count += $countones(wr_pulse_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return regs_o[i*DW +: DW];
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a >> 2) < NR;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++) chk($sformatf("%s_reg%0d", tag, i), reg_of(i), model[i]);
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (addr_ok(a)) model[a >> 2] = d;
    endtask

    task automatic write_pair(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 50) begin tick(); n++; end
        chk("wr_accept_wait", 64'(n < 50), 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("bvalid_wait", 64'(n < 50), 64'd1);
        resp = bresp;
        tick();
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        chk("ar_accept_wait", 64'(n < 50), 64'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        chk("rvalid_wait", 64'(n < 50), 64'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d, d4, d5, rd;
        logic [AW-1:0] a;
        logic [1:0]    rsp, first_resp;
        int nb, pc0;

        aresetn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        repeat (3) @(posedge aclk);
        #1;
        check_all_regs("rst");
        chk("rst_wr_pulse", wr_pulse_o, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_readies", {awready, wready, arready}, 0);
        aresetn = 1'b1;
        chk("release_readies_low", {awready, wready, arready}, 0);
        tick();
        chk("release_readies_high", {awready, wready, arready}, 3'b111);
        read_reg(32'h4, rd, rsp);
        chk("rd4_data", rd, 0);
        chk("rd4_resp", rsp, 0);

        // Same-cycle AW and W to 0x8.
        awaddr = 32'h8; wdata = 32'hDEADBEEF; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        chk("same_reg2_before", reg_of(2), 0);
        chk("same_bvalid_early", bvalid, 0);
        chk("same_readies_low", {awready, wready}, 0);
        tick();
        chk("same_reg2_after", reg_of(2), 32'hDEADBEEF);
        chk("same_pulse", wr_pulse_o, 8'h04);
        chk("same_bvalid", bvalid, 1);
        chk("same_bresp", bresp, 0);
        tick();
        chk("same_pulse_gone", wr_pulse_o, 0);
        chk("same_bvalid_gone", bvalid, 0);
        model[2] = 32'hDEADBEEF;

        // W three cycles ahead of AW to 0xC.
        wdata = 32'h12345678; wvalid = 1; bready = 1;
        tick();
        wvalid = 0;
        chk("wfirst_wready_low", wready, 0);
        chk("wfirst_awready_high", awready, 1);
        tick(); tick();
        awaddr = 32'hC; awvalid = 1;
        tick();
        awvalid = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (bvalid) nb++;
            tick();
        end
        chk("wfirst_b_count", nb, 1);
        model[3] = 32'h12345678;
        check_all_regs("wfirst");

        // Back-pressured B with a second AW waiting behind it.
        d4 = $urandom; d5 = $urandom;
        bready = 0;
        awaddr = 32'h10; wdata = d4; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        first_resp = bresp;
        chk("bp_first_resp", first_resp, 0);
        awaddr = 32'h14; awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid_hold", bvalid, 1);
            chk("bp_bresp_hold", bresp, first_resp);
            chk("bp_awready_low", awready, 0);
            tick();
        end
        chk("bp_reg4", reg_of(4), d4);
        model[4] = d4;
        bready = 1;
        tick();
        chk("bp_b_done", bvalid, 0);
        chk("bp_awready_back", awready, 1);
        tick();
        awvalid = 0;
        chk("bp_have_a_readies", {awready, wready}, 2'b01);
        wdata = d5; wvalid = 1;
        tick();
        wvalid = 0;
        tick();
        chk("bp_second_bvalid", bvalid, 1);
        tick();
        model[5] = d5;
        check_all_regs("bp");

        // Commit of a write to 0x0 coincides with an AR of 0x0.
        write_pair(32'h0, 32'h11, rsp);
        model[0] = 32'h11;
        awaddr = 32'h0; wdata = 32'hA5A5A5A5; awvalid = 1; wvalid = 1; bready = 1; rready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 32'h0; arvalid = 1;
        tick();
        arvalid = 0;
        chk("coll_rvalid", rvalid, 1);
        chk("coll_rdata_old", rdata, 32'h11);
        chk("coll_reg0_new", reg_of(0), 32'hA5A5A5A5);
        rready = 1;
        tick();
        rready = 0;
        chk("coll_rvalid_gone", rvalid, 0);
        model[0] = 32'hA5A5A5A5;
        read_reg(32'h0, rd, rsp);
        chk("coll_reread", rd, 32'hA5A5A5A5);

        // Out-of-range write and read at 0x100.
        pc0 = pulse_count;
        write_pair(32'h100, $urandom, rsp);
        chk("oor_bresp", rsp, EXP_OOR);
        chk("oor_no_pulse", pulse_count - pc0, 0);
        check_all_regs("oor");
        read_reg(32'h100, rd, rsp);
        chk("oor_rdata", rd, 0);
        chk("oor_rresp", rsp, EXP_OOR);

        // Reset landing between handshake and commit.
        awaddr = 32'h18; wdata = 32'hCAFEF00D; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        awvalid = 0; wvalid = 0;
        aresetn = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tick();
        check_all_regs("midrst");
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_readies", {awready, wready, arready}, 0);
        aresetn = 1;
        tick();

        // Randomized traffic against the array model.
        for (int it = 0; it < 40; it++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                pc0 = pulse_count;
                write_pair(a, d, rsp);
                model_write(a, d);
                chk($sformatf("rnd_bresp_%0h", a), rsp, addr_ok(a) ? 2'b00 : EXP_OOR);
                chk($sformatf("rnd_pulses_%0h", a), pulse_count - pc0, addr_ok(a) ? 1 : 0);
                check_all_regs("rnd_wr");
            end else begin
                read_reg(a, rd, rsp);
                chk($sformatf("rnd_rdata_%0h", a), rd, addr_ok(a) ? model[a >> 2] : '0);
                chk($sformatf("rnd_rresp_%0h", a), rsp, addr_ok(a) ? 2'b00 : EXP_OOR);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 The block SHALL have parameter AXI_WIDTH_ADDR, default 32: address width.
REQ-002 The block SHALL have parameter AXI_WIDTH_DATA, default 32: data and register width.
REQ-003 The block SHALL have parameter NUM_REGS, default 8: number of word registers, a power of 2, at least 2.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset (port aresetn).
REQ-005 aclk  input  1  clock; all state updates on its rising edge.
REQ-006 aresetn  input  1  asynchronous active-low reset.
REQ-007 s_axi_lite_awaddr/awvalid/awready  in/in/out  AXI_WIDTH_ADDR/1/1  write address channel.
REQ-008 s_axi_lite_wdata/wvalid/wready  in/in/out  AXI_WIDTH_DATA/1/1  write data channel; no strobes, full-word writes only.
REQ-009 s_axi_lite_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-010 s_axi_lite_araddr/arvalid/arready  in/in/out  AXI_WIDTH_ADDR/1/1  read address channel.
REQ-011 s_axi_lite_rdata/rresp/rvalid/rready  out/out/out/in  AXI_WIDTH_DATA/2/1/1  read data channel.
REQ-012 regs_o  output  NUM_REGS*AXI_WIDTH_DATA  flat register contents; register i at bits [i*AXI_WIDTH_DATA +: AXI_WIDTH_DATA].
REQ-013 wr_pulse_o  output  NUM_REGS  one-cycle strobe, bit i high in the cycle after register i is written.

Function
REQ-014 Decode SHALL be word-based: index = addr>>2, addr[1:0] ignored; index >= NUM_REGS is out of range.
REQ-015 The write FSM SHALL have states W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP.
REQ-016 The write FSM SHALL hold awready high in W_IDLE and W_HAVE_D, and wready high in W_IDLE and W_HAVE_A; both SHALL be low otherwise.
REQ-017 AW and W handshakes SHALL be accepted in either order or in the same cycle, and the latched address/data SHALL be held until commit.
REQ-018 When both are latched, the FSM SHALL enter W_COMMIT; the in-range register SHALL update at the next edge, and the FSM SHALL then enter W_RESP with bvalid=1.
REQ-019 Latency SHALL be fixed: for AW+W accepted at edge N, the register updates at N+1 and bvalid is high from N+1.
REQ-020 bvalid and bresp SHALL stay stable until bready is high; on the B handshake the FSM SHALL return to W_IDLE, so back-to-back writes take a minimum of 3 cycles.
REQ-021 The read FSM SHALL have states R_IDLE (arready=1) and R_RESP (arready=0).
REQ-022 On an AR handshake at edge N, rdata SHALL be captured from the register value before edge N writes take effect, and rvalid SHALL be high from N.
REQ-023 rvalid, rdata and rresp SHALL stay stable until rready; the handshake SHALL return the FSM to R_IDLE.
REQ-024 The read and write FSMs SHALL be independent; a simultaneous read and write of the same register returns the old value.
REQ-025 bresp and rresp SHALL be 2'b00 (OKAY) for in-range accesses.

Reset
REQ-026 While aresetn=0: all registers, rdata and wr_pulse_o SHALL be 0; bvalid=rvalid=0; bresp=rresp=0; awready=wready=arready=0; FSMs in W_IDLE/R_IDLE.
REQ-027 The ready outputs SHALL be registered so that they rise on the first edge after reset release.
REQ-028 Reset asserted mid-transaction SHALL abort it without a partial register update.

Configuration
REQ-029 Macro AXI_LITE_REG_SLAVE_SLVERR_EN SHALL select the out-of-range behaviour.
REQ-030 With AXI_LITE_REG_SLAVE_SLVERR_EN defined, an out-of-range write SHALL be dropped with bresp=2'b10, and an out-of-range read SHALL return rdata=0 with rresp=2'b10.
REQ-031 Without AXI_LITE_REG_SLAVE_SLVERR_EN, out-of-range accesses SHALL behave the same except that the response is 2'b00.

Structure
REQ-032 Package axi_lite_reg_slave_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the write/read state enums.
REQ-033 The design SHALL be a single module with no sub-module; the register array SHALL be inline.

Verification
REQ-034 Bench SHALL cover: reset release -> regs_o all 0; awready/wready/arready rise 1 cycle later; read of 0x4 -> rdata 0, rresp 00.
REQ-035 Bench SHALL cover: AW 0x8 and W 0xDEADBEEF in the same cycle, bready=1 -> reg2=0xDEADBEEF 1 cycle later; wr_pulse_o=0x04 for 1 cycle; bresp 00.
REQ-036 Bench SHALL cover: W 0x12345678 three cycles before AW 0xC -> reg3=0x12345678; exactly one B response.
REQ-037 Bench SHALL cover: bready held low 5 cycles -> bvalid/bresp stable; awready=0; a second AW stalls until the B handshake.
REQ-038 Bench SHALL cover: write 0xA5A5A5A5 to 0x0 whose commit coincides with an AR of 0x0 (old value 0x11) -> rdata=0x11; the next read returns 0xA5A5A5A5.
REQ-039 Bench SHALL cover: write and read 0x100 with NUM_REGS=8 -> no register changes; rdata=0; resp 10 with the macro and 00 without.
